// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential fetches under a credit limit, queues
// in-order responses tagged with their PC, and flushes on an EX-stage redirect.
module if_prefetch_buf #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_taken,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc_plus4
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] rsp_pc;
   logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      discard;

   logic             credit_ok;
   logic             req_fire;
   logic             rsp_take;
   logic             full;
   logic             rsp_keep;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] inflight;

   // Credit covers both queued entries and requests still in flight.
   always_comb begin
      credit_ok      = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
      imem_req_valid = !rst && !redirect_taken && credit_ok;
      imem_req_addr  = fetch_pc;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_take       = imem_rsp_valid && (outstanding != '0);
      full           = (count == CNT_W'(DEPTH));
      rsp_keep       = imem_rsp_valid && (discard == '0);
      push           = rsp_keep && !full;
      out_valid      = (count != '0);
      pop            = out_valid && out_ready;
      inflight       = rsp_take ? (outstanding - CNT_W'(1)) : outstanding;
   end

   // Head is gated so an empty buffer presents zeros rather than stale entries.
   always_comb begin
      out_pc       = '0;
      out_instr    = '0;
      out_pc_plus4 = '0;
      if (out_valid) begin
         out_pc       = pc_mem[rd_ptr];
         out_instr    = instr_mem[rd_ptr];
         out_pc_plus4 = pc_mem[rd_ptr] + ADDR_WIDTH'(4);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (redirect_taken) begin
         // Everything still in flight belongs to the old path and must be dropped.
         fetch_pc    <= redirect_addr;
         rsp_pc      <= redirect_addr;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= inflight;
         discard     <= inflight;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
         end
         outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
         if (imem_rsp_valid && (discard != '0)) begin
            discard <= discard - CNT_W'(1);
         end
         if (push) begin
            rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!redirect_taken && push) begin
         pc_mem[wr_ptr]    <= rsp_pc;
         instr_mem[wr_ptr] <= imem_rsp_data;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && !redirect_taken) begin
         assert (!(rsp_keep && full));
      end
   end
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf: vector table for streaming/back-pressure plus
// hand-written redirect and reset sequences against a latency-configurable memory model.
module tb_if_prefetch_buf;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_taken = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;

   int errors = 0;
   int checks = 0;
   int lat = 1;
   bit data_mode = 1'b0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   if_prefetch_buf #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk(clk), .rst(rst),
      .redirect_taken(redirect_taken), .redirect_addr(redirect_addr),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return data_mode ? (a ^ KEY) : 32'h0000_0013;
   endfunction

   // In-order memory: a request accepted at one edge is answered lat cycles later.
   logic [31:0] q_addr [$];
   int          q_due  [$];
   int          cyc = 0;
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            q_addr.delete();
            q_due.delete();
         end else begin
            if (imem_rsp_valid && q_addr.size() > 0) begin
               void'(q_addr.pop_front());
               void'(q_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
               q_addr.push_back(imem_req_addr);
               q_due.push_back(cyc + lat);
               hs_cnt++;
            end
         end
         cyc++;
         #1;
         if (!rst && q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(q_addr[0]);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_taken = 1'b0;
      out_ready = 1'b0;
      imem_req_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for out_valid; returns the number of cycles waited.
   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      while (!out_valid && n < maxc) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   typedef struct {
      bit          restart;
      bit          ordy;
      bit          rrdy;
      bit          rv;
      logic [31:0] ra;
      bit          ov;
      logic [31:0] opc;
   } vec_t;

   function automatic vec_t mk(bit rs, bit o, bit r, bit rv, logic [31:0] ra, bit ov,
                               logic [31:0] opc);
      vec_t v;
      v = '{rs, o, r, rv, ra, ov, opc};
      return v;
   endfunction

   vec_t vecs [$];

   initial begin
      int n;
      int base;

      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_pc_plus4", out_pc_plus4, 32'h0);

      // Streaming at one per cycle with a 1-cycle memory.
      vecs.push_back(mk(1, 1, 1, 1, 32'h00, 0, 32'h00));
      vecs.push_back(mk(0, 1, 1, 1, 32'h04, 0, 32'h00));
      vecs.push_back(mk(0, 1, 1, 1, 32'h08, 1, 32'h00));
      vecs.push_back(mk(0, 1, 1, 1, 32'h0C, 1, 32'h04));
      vecs.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h08));
      vecs.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h0C));
      // Back-pressure: 10 stalled cycles cap at 4 requests, then drain and resume.
      vecs.push_back(mk(1, 0, 1, 1, 32'h00, 0, 32'h00));
      vecs.push_back(mk(0, 0, 1, 1, 32'h04, 0, 32'h00));
      vecs.push_back(mk(0, 0, 1, 1, 32'h08, 1, 32'h00));
      vecs.push_back(mk(0, 0, 1, 1, 32'h0C, 1, 32'h00));
      for (int k = 0; k < 6; k++) vecs.push_back(mk(0, 0, 1, 0, 32'h00, 1, 32'h00));
      vecs.push_back(mk(0, 1, 1, 0, 32'h00, 1, 32'h00));
      vecs.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h04));
      vecs.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h08));
      vecs.push_back(mk(0, 1, 1, 1, 32'h18, 1, 32'h0C));
      vecs.push_back(mk(0, 1, 1, 1, 32'h1C, 1, 32'h10));
      vecs.push_back(mk(0, 1, 1, 1, 32'h20, 1, 32'h14));

      lat = 1;
      data_mode = 1'b0;
      base = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].restart) begin
            do_reset();
            base = hs_cnt;
         end
         out_ready = vecs[i].ordy;
         imem_req_ready = vecs[i].rrdy;
         #1;
         check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
         if (vecs[i].rv) check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].ra);
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         if (vecs[i].ov) begin
            check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].opc);
            check($sformatf("v%0d_out_instr", i), out_instr, 32'h13);
            check($sformatf("v%0d_out_pc_plus4", i), out_pc_plus4, vecs[i].opc + 32'h4);
         end
         if (i == 15) check("bp_hs_count", 32'(hs_cnt - base), 32'd4);
         @(negedge clk);
      end

      // Redirect with two requests in flight, memory latency 3.
      lat = 3;
      data_mode = 1'b1;
      do_reset();
      out_ready = 1'b1;
      imem_req_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      redirect_taken = 1'b1;
      redirect_addr = 32'h100;
      #1;
      check("a_redir_no_req", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      redirect_taken = 1'b0;
      #1;
      check("a_req_valid", 32'(imem_req_valid), 32'h1);
      check("a_req_addr", imem_req_addr, 32'h100);
      wait_valid(12, n);
      check("a_out_latency", 32'(n), 32'd4);
      check("a_out_pc", out_pc, 32'h100);
      check("a_out_pc_plus4", out_pc_plus4, 32'h104);
      check("a_out_instr", out_instr, 32'h100 ^ KEY);

      // Redirect in the same cycle as the only in-flight response.
      lat = 1;
      do_reset();
      out_ready = 1'b1;
      imem_req_ready = 1'b1;
      @(negedge clk);
      redirect_taken = 1'b1;
      redirect_addr = 32'h100;
      #1;
      check("b_rsp_present", 32'(imem_rsp_valid), 32'h1);
      check("b_redir_no_req", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      redirect_taken = 1'b0;
      #1;
      check("b_req_addr", imem_req_addr, 32'h100);
      check("b_dropped_c2", 32'(out_valid), 32'h0);
      @(negedge clk);
      #1;
      check("b_dropped_c3", 32'(out_valid), 32'h0);
      @(negedge clk);
      #1;
      check("b_out_valid", 32'(out_valid), 32'h1);
      check("b_out_pc", out_pc, 32'h100);
      check("b_out_instr", out_instr, 32'h100 ^ KEY);

      // Memory not ready for 5 cycles, redirect at the end of the stall.
      do_reset();
      base = hs_cnt;
      imem_req_ready = 1'b1;
      repeat (3) @(negedge clk);
      imem_req_ready = 1'b0;
      #1;
      check("c_hs_before_stall", 32'(hs_cnt - base), 32'd3);
      repeat (4) @(negedge clk);
      redirect_taken = 1'b1;
      redirect_addr = 32'h200;
      #1;
      check("c_valid_before_flush", 32'(out_valid), 32'h1);
      @(negedge clk);
      redirect_taken = 1'b0;
      #1;
      check("c_valid_after_flush", 32'(out_valid), 32'h0);
      check("c_hs_during_stall", 32'(hs_cnt - base), 32'd3);
      check("c_req_valid", 32'(imem_req_valid), 32'h1);
      check("c_req_addr", imem_req_addr, 32'h200);
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      wait_valid(12, n);
      check("c_out_latency", 32'(n), 32'd2);
      check("c_out_pc", out_pc, 32'h200);
      @(negedge clk);
      #1;
      check("c_out_pc_next", out_pc, 32'h204);

      // Asynchronous reset in the middle of streaming.
      data_mode = 1'b0;
      do_reset();
      out_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("d_pre_out_pc", out_pc, 32'h8);
      #1;
      rst = 1'b1;
      #1;
      check("d_async_out_valid", 32'(out_valid), 32'h0);
      check("d_async_out_pc", out_pc, 32'h0);
      check("d_async_out_instr", out_instr, 32'h0);
      check("d_async_out_pc_plus4", out_pc_plus4, 32'h0);
      check("d_async_req_valid", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("d_req_valid", 32'(imem_req_valid), 32'h1);
      check("d_req_addr", imem_req_addr, 32'h0);
      @(negedge clk);
      #1;
      check("d_c1_out_valid", 32'(out_valid), 32'h0);
      check("d_c1_req_addr", imem_req_addr, 32'h4);
      @(negedge clk);
      #1;
      check("d_c2_out_valid", 32'(out_valid), 32'h1);
      check("d_c2_out_pc", out_pc, 32'h0);
      check("d_c2_out_pc_plus4", out_pc_plus4, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
